// File: rtl/lab4d_dma_reader.sv
// Wishbone read master draining the LAB4D readout FIFOs onto a stream.
// Define LAB4D_DMA_HEADER_EN to prefix each enabled LAB with a header beat.
module lab4d_dma_reader #(
  parameter int NUM_LAB4    = 24,
  parameter int LEN_BITS    = 10,
  parameter int ACK_TIMEOUT = 255,
  parameter int L4W         = $clog2(NUM_LAB4)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [NUM_LAB4-1:0] lab_mask_i,
  input  logic [LEN_BITS-1:0] nwords_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                dma_lock_o,
  input  logic                dma_locked_i,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [15:0]         wb_adr_o,
  output logic [3:0]          wb_sel_o,
  input  logic [31:0]         wb_dat_i,
  input  logic                wb_ack_i,
  output logic [31:0]         m_tdata,
  output logic [L4W-1:0]      m_tuser,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready
);

  localparam int LW = $clog2(NUM_LAB4 + 1);
  localparam int AW = 16 - L4W;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOCK, S_SEL, S_REQ,
    S_PUSH, S_UNLOCK, S_DONE, S_HDR
  } state_t;

  state_t state, nxt;

  logic [NUM_LAB4-1:0] mask;
  logic [LEN_BITS-1:0] nwords;
  logic [LEN_BITS-1:0] word;
  logic [LW-1:0]       lab;
  logic [31:0]         data;
  logic [TW-1:0]       tmo;
  logic                err;
  logic                abt;

  logic          mask_bit;
  logic          sel_end;
  logic          last;
  logic          beat;
  logic          tmo_hit;
  logic [AW-1:0] adr_lo;

  assign mask_bit = mask[lab[L4W-1:0]];
  assign sel_end  = (lab >= LW'(NUM_LAB4)) || (nwords == '0);
  assign last     = (word == LEN_BITS'(nwords - 1'b1));
  assign beat     = m_tvalid && m_tready;
  assign tmo_hit  = (tmo == TW'(ACK_TIMEOUT - 1));
  assign adr_lo   = AW'({word, 2'b00});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (start_i) nxt = S_LOCK;
      S_LOCK: begin
        if (abort_i)           nxt = S_UNLOCK;
        else if (dma_locked_i) nxt = S_SEL;
      end
      S_SEL: begin
        if (abort_i || sel_end) nxt = S_UNLOCK;
`ifdef LAB4D_DMA_HEADER_EN
        else if (mask_bit)      nxt = S_HDR;
`else
        else if (mask_bit)      nxt = S_REQ;
`endif
      end
      S_HDR: begin
        if (abort_i)       nxt = S_UNLOCK;
        else if (m_tready) nxt = S_REQ;
      end
      S_REQ: begin
        // an aborted read still has to finish on the bus
        if (wb_ack_i)     nxt = (abt || abort_i) ? S_UNLOCK : S_PUSH;
        else if (tmo_hit) nxt = S_UNLOCK;
      end
      S_PUSH: begin
        if (abort_i)       nxt = S_UNLOCK;
        else if (m_tready) nxt = last ? S_SEL : S_REQ;
      end
      S_UNLOCK: if (!dma_locked_i) nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask   <= '0;
      nwords <= '0;
      word   <= '0;
      lab    <= '0;
      data   <= '0;
      tmo    <= '0;
      err    <= 1'b0;
      abt    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            mask   <= lab_mask_i;
            nwords <= nwords_i;
            lab    <= '0;
            err    <= 1'b0;
            abt    <= 1'b0;
          end
        end
        S_SEL: begin
          word <= '0;
          tmo  <= '0;
          if (!sel_end && !mask_bit) lab <= lab + 1'b1;
        end
        S_REQ: begin
          if (abort_i) abt <= 1'b1;
          if (wb_ack_i)     data <= wb_dat_i;
          else if (tmo_hit) err  <= 1'b1;
          else              tmo  <= tmo + 1'b1;
        end
        S_PUSH: begin
          if (beat && !abort_i) begin
            tmo <= '0;
            if (last) lab  <= lab + 1'b1;
            else      word <= word + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o     = 1'b0;
    done_o     = 1'b0;
    dma_lock_o = 1'b0;
    wb_cyc_o   = 1'b0;
    wb_stb_o   = 1'b0;
    m_tvalid   = 1'b0;
    m_tlast    = 1'b0;
    m_tdata    = data;
    unique case (state)
      S_LOCK, S_SEL: begin
        busy_o     = 1'b1;
        dma_lock_o = 1'b1;
      end
      S_HDR: begin
        busy_o     = 1'b1;
        dma_lock_o = 1'b1;
        m_tvalid   = 1'b1;
        m_tdata    = {8'hA5, 3'b000, 5'(lab), 16'(nwords)};
      end
      S_REQ: begin
        busy_o     = 1'b1;
        dma_lock_o = 1'b1;
        wb_cyc_o   = 1'b1;
        wb_stb_o   = 1'b1;
      end
      S_PUSH: begin
        busy_o     = 1'b1;
        dma_lock_o = 1'b1;
        m_tvalid   = 1'b1;
        m_tlast    = last;
      end
      S_UNLOCK: busy_o = 1'b1;
      S_DONE:   done_o = 1'b1;
      default: ;
    endcase
  end

  assign err_o    = err;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'hF;
  assign wb_adr_o = {lab[L4W-1:0], adr_lo};
  assign m_tuser  = lab[L4W-1:0];

endmodule
